// File: rtl/hub75_pkg.sv
// rtl/hub75_pkg.sv - shared constants, state encoding and helpers for the HUB75 frame-buffer DMA
package hub75_pkg;

    localparam logic [31:0] HUB_BASE_DEFAULT = 32'h8100_0000;
    localparam int          CTRL_SEL_BIT     = 0;
    localparam int          CTRL_VSYNC_BIT   = 8;

    typedef logic [2:0] dma_state_t;
    localparam dma_state_t IDLE = 3'd0;
    localparam dma_state_t CLR  = 3'd1;
    localparam dma_state_t RD   = 3'd2;
    localparam dma_state_t WR   = 3'd3;
    localparam dma_state_t POLL = 3'd4;
    localparam dma_state_t GAP  = 3'd5;
    localparam dma_state_t SWAP = 3'd6;
    localparam dma_state_t DONE = 3'd7;

    // The control word lives directly after both pixel buffers.
    function automatic logic [31:0] ctrl_offset_w(input int rows, input int cols);
        return 32'(2 * rows * cols);
    endfunction

    // Every control write also clears the vsync flag.
    function automatic logic [31:0] ctrl_word(input logic sel);
        logic [31:0] w;
        w                 = '0;
        w[CTRL_VSYNC_BIT] = 1'b1;
        w[CTRL_SEL_BIT]   = sel;
        return w;
    endfunction

endpackage

// File: rtl/hub75_px_unpack.sv
// rtl/hub75_px_unpack.sv - source word to 24-bit 0xBBGGRR pixel (direct or RGB565 half-word expand)
module hub75_px_unpack (
    input  logic        half_sel_i,
    input  logic [31:0] src_word_i,
    input  logic        fmt_i,
    output logic [23:0] pixel_o
);

    logic [15:0] h;
    logic [7:0]  r8;
    logic [7:0]  g8;
    logic [7:0]  b8;

    always_comb begin
        h  = half_sel_i ? src_word_i[31:16] : src_word_i[15:0];
        // Replicate MSBs into the LSBs so full-scale 5/6-bit maps to 0xFF.
        r8 = {h[15:11], h[15:13]};
        g8 = {h[10:5], h[10:9]};
        b8 = {h[4:0], h[4:2]};
        pixel_o = fmt_i ? {b8, g8, r8} : src_word_i[23:0];
    end

endmodule

// File: rtl/hub75_fb_dma.sv
// rtl/hub75_fb_dma.sv - frame copy engine: source memory to HUB75 back buffer, vsync wait, buffer flip
module hub75_fb_dma
    import hub75_pkg::*;
#(
    parameter int          ROWS       = 64,
    parameter int          COLS       = 64,
    parameter logic [31:0] HUB_BASE   = HUB_BASE_DEFAULT,
    parameter int          SRC_RGB565 = 0,
    parameter int          POLL_GAP   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [31:0] src_base_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        front_o,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_wdata_o,
    output logic [3:0]  m_wmask_o,
    output logic        m_wen_o,
    output logic        m_ren_o,
    input  logic [31:0] m_rdata_i,
    input  logic        m_ready_i
);

    localparam int               NPIX      = ROWS * COLS;
    localparam int               PIX_W     = $clog2(NPIX);
    localparam int               GAP_W     = $clog2(POLL_GAP + 1);
    localparam logic [31:0]      NPIX_W    = 32'(NPIX);
    localparam logic [31:0]      CTRL_ADDR = HUB_BASE + (ctrl_offset_w(ROWS, COLS) << 2);
    localparam logic [PIX_W-1:0] LAST_PIX  = PIX_W'(NPIX - 1);
    localparam logic             FMT565    = (SRC_RGB565 != 0);

    dma_state_t       state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             front_q, front_d;
    logic             half_q, half_d;
    logic [PIX_W-1:0] pix_q, pix_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [31:0]      src_addr_q, src_addr_d;
    logic [31:0]      src_word_q, src_word_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wmask_q, wmask_d;
    logic             wen_q, wen_d;
    logic             ren_q, ren_d;

    logic             pending;
    logic             ack;
    logic [23:0]      pixel;
    logic [31:0]      pix_word;
    logic [31:0]      dest_addr;

    hub75_px_unpack u_unpack (
        .half_sel_i (half_q),
        .src_word_i (src_word_q),
        .fmt_i      (FMT565),
        .pixel_o    (pixel)
    );

    assign pending   = wen_q | ren_q;
    assign ack       = pending & m_ready_i;
    // Back buffer is the one not on display: index ~front.
    assign pix_word  = (front_q ? 32'd0 : NPIX_W) + 32'(pix_q);
    assign dest_addr = HUB_BASE + (pix_word << 2);

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        front_d    = front_q;
        half_d     = half_q;
        pix_d      = pix_q;
        gap_d      = gap_q;
        src_addr_d = src_addr_q;
        src_word_d = src_word_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        wen_d      = wen_q;
        ren_d      = ren_q;

        // A completed transaction always drops the request, giving one idle cycle.
        if (ack) begin
            wen_d = 1'b0;
            ren_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    busy_d     = 1'b1;
                    src_addr_d = src_base_i;
                    pix_d      = '0;
                    half_d     = 1'b0;
                    state_d    = CLR;
                end
            end
            CLR: begin
                if (!pending) begin
                    addr_d  = CTRL_ADDR;
                    wdata_d = ctrl_word(front_q);
                    wmask_d = 4'b0011;
                    wen_d   = 1'b1;
                end else if (m_ready_i) begin
                    state_d = RD;
                end
            end
            RD: begin
                if (!pending) begin
                    addr_d  = src_addr_q;
                    wmask_d = 4'b0000;
                    ren_d   = 1'b1;
                end else if (m_ready_i) begin
                    src_word_d = m_rdata_i;
                    src_addr_d = src_addr_q + 32'd4;
                    state_d    = WR;
                end
            end
            WR: begin
                if (!pending) begin
                    addr_d  = dest_addr;
                    wdata_d = {8'h00, pixel};
                    wmask_d = 4'b0111;
                    wen_d   = 1'b1;
                end else if (m_ready_i) begin
                    if (pix_q == LAST_PIX) begin
                        pix_d   = '0;
                        half_d  = 1'b0;
                        state_d = POLL;
                    end else begin
                        pix_d = pix_q + PIX_W'(1);
                        if (FMT565 && !half_q) begin
                            half_d = 1'b1;
                        end else begin
                            half_d  = 1'b0;
                            state_d = RD;
                        end
                    end
                end
            end
            POLL: begin
                if (!pending) begin
                    addr_d  = CTRL_ADDR;
                    wmask_d = 4'b0000;
                    ren_d   = 1'b1;
                end else if (m_ready_i) begin
                    if (m_rdata_i[CTRL_VSYNC_BIT]) begin
                        state_d = SWAP;
                    end else begin
                        gap_d   = GAP_W'(POLL_GAP - 1);
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = POLL;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            SWAP: begin
                if (!pending) begin
                    addr_d  = CTRL_ADDR;
                    wdata_d = ctrl_word(~front_q);
                    wmask_d = 4'b0011;
                    wen_d   = 1'b1;
                end else if (m_ready_i) begin
                    front_d = ~front_q;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            front_q    <= 1'b0;
            half_q     <= 1'b0;
            pix_q      <= '0;
            gap_q      <= '0;
            src_addr_q <= '0;
            src_word_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            wen_q      <= 1'b0;
            ren_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            front_q    <= front_d;
            half_q     <= half_d;
            pix_q      <= pix_d;
            gap_q      <= gap_d;
            src_addr_q <= src_addr_d;
            src_word_q <= src_word_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            wen_q      <= wen_d;
            ren_q      <= ren_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign front_o   = front_q;
    assign m_addr_o  = addr_q;
    assign m_wdata_o = wdata_q;
    assign m_wmask_o = wmask_q;
    assign m_wen_o   = wen_q;
    assign m_ren_o   = ren_q;

endmodule

// File: tb/tb_hub75_fb_dma.sv
// tb/tb_hub75_fb_dma.sv - directed bench for hub75_fb_dma with a random-latency bus and vsync model
module tb_hub75_fb_dma;

    localparam int          ROWS     = 4;
    localparam int          COLS     = 4;
    localparam int          NPIX     = ROWS * COLS;
    localparam int          POLL_GAP = 4;
    localparam logic [31:0] HUB      = 32'h8100_0000;
    localparam logic [31:0] CTRL     = HUB + 32'h80;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start    [2];
    logic [31:0] src_base [2];
    logic        busy     [2];
    logic        done     [2];
    logic        front    [2];
    logic [31:0] m_addr   [2];
    logic [31:0] m_wdata  [2];
    logic [3:0]  m_wmask  [2];
    logic        m_wen    [2];
    logic        m_ren    [2];
    logic [31:0] m_rdata  [2];
    logic        m_ready  [2];

    always #5 clk = ~clk;

    hub75_fb_dma #(.ROWS(ROWS), .COLS(COLS), .HUB_BASE(HUB), .SRC_RGB565(0), .POLL_GAP(POLL_GAP)) u_dut (
        .clk(clk), .rst_n(rst_n), .start_i(start[0]), .src_base_i(src_base[0]),
        .busy_o(busy[0]), .done_o(done[0]), .front_o(front[0]),
        .m_addr_o(m_addr[0]), .m_wdata_o(m_wdata[0]), .m_wmask_o(m_wmask[0]),
        .m_wen_o(m_wen[0]), .m_ren_o(m_ren[0]), .m_rdata_i(m_rdata[0]), .m_ready_i(m_ready[0])
    );

    hub75_fb_dma #(.ROWS(ROWS), .COLS(COLS), .HUB_BASE(HUB), .SRC_RGB565(1), .POLL_GAP(POLL_GAP)) u_rgb (
        .clk(clk), .rst_n(rst_n), .start_i(start[1]), .src_base_i(src_base[1]),
        .busy_o(busy[1]), .done_o(done[1]), .front_o(front[1]),
        .m_addr_o(m_addr[1]), .m_wdata_o(m_wdata[1]), .m_wmask_o(m_wmask[1]),
        .m_wen_o(m_wen[1]), .m_ren_o(m_ren[1]), .m_rdata_i(m_rdata[1]), .m_ready_i(m_ready[1])
    );

    int n_compared   = 0;
    int n_mismatched = 0;
    int proto_err    = 0;
    int gap_err      = 0;
    int ctrl_reads  [2];
    int src_reads   [2];
    int poll_cnt    [2];
    int txn_started [2];
    int dly         [2];
    int idle_run    [2];
    logic        pend      [2];
    logic        last_poll [2];
    logic [31:0] s_addr    [2];
    logic [31:0] s_wdata   [2];
    logic [3:0]  s_mask    [2];
    logic        s_wen     [2];
    logic        s_ren     [2];
    wr_t wlog0[$];
    wr_t wlog1[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Bus slave + protocol monitor; observes and drives on the falling edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_ready[k]   = 1'b0;
                m_rdata[k]   = '0;
                pend[k]      = 1'b0;
                last_poll[k] = 1'b0;
                idle_run[k]  = 0;
                poll_cnt[k]  = 0;
            end else if (m_ready[k]) begin
                m_ready[k] = 1'b0;
                m_rdata[k] = $urandom;
                if (m_ren[k] | m_wen[k]) proto_err++;
                idle_run[k] = 1;
            end else if (m_ren[k] | m_wen[k]) begin
                if (m_ren[k] & m_wen[k]) proto_err++;
                if (m_ren[k] && m_wmask[k] != 4'h0) proto_err++;
                if (pend[k]) begin
                    if (m_addr[k] !== s_addr[k] || m_wdata[k] !== s_wdata[k] || m_wmask[k] !== s_mask[k] ||
                        m_wen[k] !== s_wen[k] || m_ren[k] !== s_ren[k]) proto_err++;
                end else begin
                    if (m_ren[k] && m_addr[k] == CTRL && last_poll[k] && idle_run[k] < POLL_GAP) gap_err++;
                    s_addr[k]  = m_addr[k];
                    s_wdata[k] = m_wdata[k];
                    s_mask[k]  = m_wmask[k];
                    s_wen[k]   = m_wen[k];
                    s_ren[k]   = m_ren[k];
                    pend[k]    = 1'b1;
                    txn_started[k]++;
                    dly[k] = int'($urandom_range(0, 3));
                end
                if (dly[k] == 0) begin
                    m_ready[k]   = 1'b1;
                    pend[k]      = 1'b0;
                    last_poll[k] = m_ren[k] && (m_addr[k] == CTRL);
                    if (m_ren[k]) begin
                        if (m_addr[k] == CTRL) begin
                            m_rdata[k] = (poll_cnt[k] >= 2) ? 32'h100 : 32'h0;
                            poll_cnt[k]++;
                            ctrl_reads[k]++;
                        end else begin
                            m_rdata[k] = (k == 0) ? ((m_addr[k] - 32'h1000) >> 2) : 32'hFFFF_F800;
                            src_reads[k]++;
                        end
                    end else begin
                        if (k == 0) wlog0.push_back(wr_t'{m_addr[k], m_wdata[k], m_wmask[k]});
                        else        wlog1.push_back(wr_t'{m_addr[k], m_wdata[k], m_wmask[k]});
                        if (m_addr[k] == CTRL && m_wdata[k][8]) poll_cnt[k] = 0;
                    end
                end else begin
                    dly[k]--;
                end
                idle_run[k] = 0;
            end else begin
                if (pend[k]) proto_err++;
                idle_run[k]++;
            end
        end
    end

    task automatic pulse_start(input int k, input logic [31:0] base);
        @(negedge clk);
        start[k]    = 1'b1;
        src_base[k] = base;
        @(negedge clk);
        start[k]    = 1'b0;
    endtask

    task automatic wait_done(input int k, input string tag);
        int cyc;
        cyc = 0;
        while (done[k] !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check_eq($sformatf("%s_done_seen", tag), 32'(done[k]), 32'd1);
    endtask

    task automatic check_frame(input int k, input string tag, input int first,
                               input logic [31:0] pix_base, input logic [31:0] clr_d, input logic [31:0] swap_d);
        wr_t         w;
        int          n;
        logic [31:0] exp_d;
        n = ((k == 0) ? wlog0.size() : wlog1.size()) - first;
        check_eq($sformatf("%s_nwrites", tag), 32'(n), 32'(NPIX + 2));
        if (n == NPIX + 2) begin
            for (int i = 0; i < n; i++) begin
                if (k == 0) w = wlog0[first + i];
                else        w = wlog1[first + i];
                if (i == 0 || i == n - 1) begin
                    check_eq($sformatf("%s_ctl%0d_addr", tag, i), w.addr, CTRL);
                    check_eq($sformatf("%s_ctl%0d_data", tag, i), w.data, (i == 0) ? clr_d : swap_d);
                    check_eq($sformatf("%s_ctl%0d_mask", tag, i), 32'(w.mask), 32'h3);
                end else begin
                    if (k == 0) exp_d = 32'(i - 1);
                    else        exp_d = ((i - 1) % 2 == 0) ? 32'h0000_00FF : 32'h00FF_FFFF;
                    check_eq($sformatf("%s_px%0d_addr", tag, i - 1), w.addr, pix_base + 32'(4 * (i - 1)));
                    check_eq($sformatf("%s_px%0d_data", tag, i - 1), w.data, exp_d);
                    check_eq($sformatf("%s_px%0d_mask", tag, i - 1), 32'(w.mask), 32'h7);
                end
            end
        end
    endtask

    int first;
    int c0;
    int s0;
    int t0;
    int cyc;

    initial begin
        rst_n       = 1'b0;
        start[0]    = 1'b0;
        start[1]    = 1'b0;
        src_base[0] = '0;
        src_base[1] = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("rst%0d_ctl", k), {27'd0, busy[k], done[k], front[k], m_wen[k], m_ren[k]}, 32'd0);
            check_eq($sformatf("rst%0d_addr", k), m_addr[k], 32'd0);
            check_eq($sformatf("rst%0d_wdata", k), m_wdata[k], 32'd0);
            check_eq($sformatf("rst%0d_wmask", k), 32'(m_wmask[k]), 32'd0);
        end
        #1 rst_n = 1'b1;

        // Frame 1: front 0, copy into buffer 1.
        first = wlog0.size(); c0 = ctrl_reads[0]; s0 = src_reads[0];
        pulse_start(0, 32'h1000);
        check_eq("f1_busy", 32'(busy[0]), 32'd1);
        wait_done(0, "f1");
        check_eq("f1_front", 32'(front[0]), 32'd1);
        check_frame(0, "f1", first, HUB + 32'h40, 32'h100, 32'h101);
        check_eq("f1_polls", 32'(ctrl_reads[0] - c0), 32'd3);
        check_eq("f1_srcrd", 32'(src_reads[0] - s0), 32'(NPIX));
        @(negedge clk);
        check_eq("f1_busy_after", 32'(busy[0]), 32'd0);
        check_eq("f1_done_after", 32'(done[0]), 32'd0);

        // Frame 2: extra starts while busy and one on the done cycle must be ignored.
        first = wlog0.size(); c0 = ctrl_reads[0];
        pulse_start(0, 32'h1000);
        repeat (5) @(negedge clk);
        pulse_start(0, 32'h2000);
        pulse_start(0, 32'h3000);
        wait_done(0, "f2");
        check_eq("f2_front", 32'(front[0]), 32'd0);
        start[0]    = 1'b1;
        src_base[0] = 32'h2000;
        @(negedge clk);
        start[0]    = 1'b0;
        check_eq("f2_start_at_done", 32'(busy[0]), 32'd0);
        t0 = txn_started[0];
        check_frame(0, "f2", first, HUB, 32'h101, 32'h100);
        check_eq("f2_polls", 32'(ctrl_reads[0] - c0), 32'd3);
        repeat (20) @(negedge clk);
        check_eq("f2_idle_txn", 32'(txn_started[0] - t0), 32'd0);

        // RGB565 source on the second instance.
        first = wlog1.size(); s0 = src_reads[1];
        pulse_start(1, 32'h4000);
        wait_done(1, "rgb");
        check_eq("rgb_front", 32'(front[1]), 32'd1);
        check_frame(1, "rgb", first, HUB + 32'h40, 32'h100, 32'h101);
        check_eq("rgb_srcrd", 32'(src_reads[1] - s0), 32'(NPIX / 2));

        // Reset in the middle of a source read.
        pulse_start(1, 32'h4000);
        cyc = 0;
        while (!(m_ren[1] && m_addr[1] != CTRL) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("mid_rd_seen", 32'(m_ren[1]), 32'd1);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mid_rst_ctl", {27'd0, busy[1], done[1], front[1], m_wen[1], m_ren[1]}, 32'd0);
        check_eq("mid_rst_addr", m_addr[1], 32'd0);
        check_eq("mid_rst_wmask", 32'(m_wmask[1]), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        t0 = txn_started[1];
        repeat (20) @(negedge clk);
        check_eq("mid_rst_no_req", 32'(txn_started[1] - t0), 32'd0);

        check_eq("proto_viol", 32'(proto_err), 32'd0);
        check_eq("poll_gap_viol", 32'(gap_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
